// File: rtl/alu_trace_buffer.sv
// Trace capture stage behind alu_regfile: samples ALU result/dest/flags, waits for a trigger,
// stores a bounded run in a show-ahead FIFO and drains it through a valid/ready read port.

package alu_trace_buffer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned FLAG_W = 5;

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [REG_W-1:0]  dest_reg;
        logic [DATA_W-1:0] alu_bus;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

module alu_trace_buffer
    import alu_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned CAPTURE_LEN = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  trig_en,
    input  logic [15:0]           trig_value,
    input  logic [15:0]           alu_bus,
    input  logic [2:0]            dest_reg,
    input  logic [4:0]            flags,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [23:0]           rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic [15:0]           dropped,
    output logic [1:0]            state
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam int unsigned SLOT_W = 16;

    state_t                 state_q;
    state_t                 state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   valid_q;
    logic [15:0]            dropped_q;
    logic [SLOT_W-1:0]      slot_q;
    sample_t                mem [DEPTH];

    sample_t                sample_in;
    logic                   wr_req;
    logic                   slot_first;
    logic                   slot_next;
    logic                   run_clear;
    logic                   pop;
    logic                   full;
    logic                   hit;
    logic                   wr_en;
    logic                   drop;

    assign sample_in = {flags, dest_reg, alu_bus};
    assign pop       = valid_q && rd_ready;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign hit       = !trig_en || (alu_bus == trig_value);
    // A full FIFO still accepts the slot when the head leaves in the same cycle.
    assign wr_en     = wr_req && (!full || pop);
    assign drop      = wr_req && !wr_en;

    // Next-state and slot control
    always_comb begin
        state_d    = state_q;
        wr_req     = 1'b0;
        slot_first = 1'b0;
        slot_next  = 1'b0;
        run_clear  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    run_clear = 1'b1;
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (hit) begin
                    wr_req     = 1'b1;
                    slot_first = 1'b1;
                    state_d    = (CAPTURE_LEN == 1) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else begin
                    wr_req    = 1'b1;
                    slot_next = 1'b1;
                    // slot_q holds slots already taken; this cycle is the last one
                    if (slot_q == SLOT_W'(CAPTURE_LEN - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Occupancy update
    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            dropped_q <= '0;
            slot_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            if (run_clear) begin
                dropped_q <= '0;
                slot_q    <= '0;
            end else begin
                if (slot_first) begin
                    slot_q <= SLOT_W'(1);
                end else if (slot_next) begin
                    slot_q <= slot_q + SLOT_W'(1);
                end
                if (drop && (dropped_q != 16'hFFFF)) begin
                    dropped_q <= dropped_q + 16'd1;
                end
            end
        end
    end

    // Sample storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign rd_valid = valid_q;
    assign count    = count_q;
    assign dropped  = dropped_q;
    assign state    = state_q;

endmodule

// File: doc/alu_trace_buffer.md
# alu_trace_buffer

Trace capture stage that sits directly downstream of `alu_regfile`. It samples the ALU result bus, the destination register index and the flags on every clock, waits for an optional trigger value, stores a bounded run of samples in a small FIFO, and lets a slower consumer drain them through a valid/ready read port. The consumer can be a display driver, a UART, or a bench. It is the observation point for controller demos such as the Fibonacci sequencer.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries.
- `CAPTURE_LEN`, default 16: number of sample slots in one capture run, counting both accepted and dropped samples. Range 1..65535.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high. Clears all state, the FIFO pointers and all counters.
- `arm`  in  1: single-cycle pulse that starts a capture run. It is honoured only in IDLE or DONE.
- `stop`  in  1: aborts an active run and moves the block to DONE.
- `trig_en`  in  1: 1 means wait for `alu_bus == trig_value`; 0 means capture starts immediately.
- `trig_value`  in  16: trigger compare value.
- `alu_bus`  in  16: ALU result from `alu_regfile`.
- `dest_reg`  in  3: destination register index for the current cycle.
- `flags`  in  5: ALU flags for the current cycle.
- `rd_ready`  in  1: consumer accepts the FIFO head.
- `rd_valid`  out  1: FIFO is non-empty.
- `rd_data`  out  24: FIFO head, packed as {flags, dest_reg, alu_bus}, with flags in bits [23:19].
- `count`  out  DEPTH_LOG2+1: current FIFO occupancy.
- `dropped`  out  16: samples lost to a full FIFO in the current run. Saturates at 16'hFFFF.
- `state`  out  2: 0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE.

## Operation
State machine:
- **IDLE.** `arm` moves to ARMED. It clears `dropped` and the slot counter. FIFO contents are kept.
- **ARMED.** The trigger condition is met when `trig_en = 0`, or when `trig_en = 1` and `alu_bus == trig_value`.
  - On the trigger, that cycle's sample is the first slot and is written. The block moves to CAPTURE, or straight to DONE if `CAPTURE_LEN = 1`.
  - Otherwise the block stays in ARMED and writes nothing.
- **CAPTURE.** Every cycle is one slot.
  - The sample is written if the FIFO is not full, or if it is full and a read pop happens in the same cycle.
  - Otherwise the sample is discarded and `dropped` increments (saturating).
  - After the slot numbered CAPTURE_LEN, the block moves to DONE.
- **DONE.** No writes. `arm` starts a new run exactly as it does from IDLE.
- **stop.** In ARMED or CAPTURE, `stop` moves to DONE at the next edge and the current cycle's sample is not written. `stop` has priority over the trigger and over the slot write. In IDLE or DONE it is ignored.
- **arm in ARMED or CAPTURE** is ignored.

Read port:
- Show-ahead FIFO. `rd_data` is the head entry whenever `rd_valid = 1`. The value is don't-care when empty.
- Pop happens when `rd_valid && rd_ready`. Reads are allowed in every state, including during a capture run.
- Pointers wrap modulo 2^DEPTH_LOG2.
- `count` updates as follows: write only, +1; pop only, −1; write and pop together, unchanged.

Boundary conditions:
- Pop on an empty FIFO is impossible, because `rd_valid = 0`.
- Write while full with a simultaneous pop is accepted.
- Reset in any state, including mid-run, returns to IDLE with an empty FIFO.

## Timing
- **Reset values:** `state` = 0, `count` = 0, `rd_valid` = 0, `dropped` = 0. `rd_data` is don't-care.
- **Sample alignment:** the sample captured is the value of `alu_bus`, `dest_reg` and `flags` present before the edge, i.e. the combinational ALU result of that cycle.
- **Write latency:** a sample written at edge N is visible on `rd_data`, with `rd_valid = 1`, after edge N if the FIFO was empty. Latency is one cycle.
- **Pop:** a pop at edge N presents the next entry immediately after edge N.
- **Trigger:** the trigger compare is combinational on the current inputs. The state change is registered at the same edge as the first write.
- **Run length:** a capture run lasts exactly CAPTURE_LEN edges, counted from and including the trigger edge, unless `stop` ends it early.

## Test plan
- Reset with defaults, then `arm` with `trig_en = 0` while driving `alu_bus` = 1..16 and `rd_ready = 0`. Required response: 16 entries captured, `count` = 16, `dropped` = 0, `state` = 3. Draining returns 1..16 in order.
- Fibonacci stimulus 1,1,2,3,5,8,13,… with `trig_en = 1`, `trig_value` = 8, `CAPTURE_LEN` = 4. Required response: FIFO holds 8, 13, 21, 34.
- `DEPTH_LOG2` = 2 with 10 slots and `rd_ready = 0`. Required response: `count` = 4, `dropped` = 6. Then hold `rd_ready = 1` on full: each pop admits the simultaneous write, and `count` stays at 4.
- Pulse `stop` on the third CAPTURE slot. Required response: exactly 2 entries stored, `state` = 3 on the next edge.
- Assert `reset` mid-CAPTURE with 5 entries stored. Required response: next cycle `state` = 0, `count` = 0, `rd_valid` = 0, `dropped` = 0.
- Continuous `rd_ready = 1` during a 20-slot run with depth 16. Required response: `dropped` = 0, and entry N appears on `rd_data` one cycle after its capture edge.
